// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: queue entry layout and address helpers.
package fetch_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [XLEN-1:0]    pc;
        logic               misaligned;
    } fetch_entry_t;

    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with a single-cycle clear; the head is read straight from storage.
module sync_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  T              din,
    input  logic          pop,
    output T              dout,
    output logic [CW-1:0] count,
    output logic          empty
);

    T              mem_q [DEPTH];
    T              mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full;
    logic          do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        // A clear wins over everything, including a pop seen by the consumer.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: one imem read per cycle under credit control, returned words queued with their PC for decode.
module instr_fetch_queue #(
    parameter int XLEN  = fetch_pkg::XLEN,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    output logic            pc_en,
    input  logic            flush,
    output logic            imem_en,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic            if_misaligned
);

    import fetch_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   count;
    logic            empty;
    logic            issue;
    logic            push;
    logic            pop;
    fetch_entry_t    wr_entry;
    fetch_entry_t    head;

    always_comb begin
        // Queued entries plus the read in flight must always fit, so a return never finds the queue full.
        issue      = rst && !flush && ((count + CW'(inflight_q)) < CW'(DEPTH));
        inflight_d = issue;
        pc_d       = issue ? pc : pc_q;
        push       = inflight_q && !flush;
        pop        = if_valid && if_ready;
        wr_entry            = '0;
        wr_entry.instr      = imem_rdata;
        wr_entry.pc         = pc_q;
        wr_entry.misaligned = is_misaligned(pc_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_q <= 1'b0;
            pc_q       <= '0;
        end else begin
            inflight_q <= inflight_d;
            pc_q       <= pc_d;
        end
    end

    sync_fifo #(
        .T     (fetch_entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .flush (flush),
        .push  (push),
        .din   (wr_entry),
        .pop   (pop),
        .dout  (head),
        .count (count),
        .empty (empty)
    );

    assign pc_en         = issue;
    assign imem_en       = issue;
    assign imem_addr     = pc;
    assign if_valid      = !empty;
    assign if_instr      = head.instr;
    assign if_pc         = head.pc;
    assign if_misaligned = head.misaligned;

endmodule
